// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and capture stage feeding the select lines of an 8:1 byte mux.
// Grants one requesting channel, captures the mux byte one cycle later and
// presents it downstream with a valid/ready handshake.
module mux_rr_arbiter #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        req,
  input  logic [DATA_W-1:0] mux_y,
  output logic              s0,
  output logic              s1,
  output logic              s2,
  output logic [7:0]        gnt,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_ch,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned NCH  = 8;
  localparam int unsigned CH_W = 3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [CH_W-1:0]   last, last_nxt;
  logic [CH_W-1:0]   sel, sel_nxt;
  logic [NCH-1:0]    gnt_q, gnt_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic [CH_W-1:0]   ch_q, ch_nxt;
  logic              valid_q, valid_nxt;

  logic [CH_W-1:0]   win;
  logic [CH_W-1:0]   idx;
  logic              found;
  logic              arb;

  // Round-robin search: first set request bit after the last granted channel, wrapping.
  always_comb begin
    win   = last;
    idx   = last;
    found = 1'b0;
    for (int i = 1; i <= int'(NCH); i++) begin
      idx = last + CH_W'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Next-state and next register values for the IDLE / CAPTURE / WAIT sequence.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    sel_nxt   = sel;
    gnt_nxt   = '0;
    data_nxt  = data_q;
    ch_nxt    = ch_q;
    valid_nxt = valid_q;
    arb       = 1'b0;

    case (state)
      ST_IDLE: begin
        arb = found;
      end
      ST_CAPTURE: begin
        data_nxt  = mux_y;
        ch_nxt    = sel;
        valid_nxt = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (out_ready) begin
          valid_nxt = 1'b0;
          if (found) begin
            arb = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (arb) begin
      sel_nxt   = win;
      gnt_nxt   = NCH'(1) << win;
      last_nxt  = win;
      state_nxt = ST_CAPTURE;
    end
  end

  // State and output registers; synchronous reset drops any in-flight capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      last    <= CH_W'(NCH - 1);
      sel     <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      last    <= last_nxt;
      sel     <= sel_nxt;
      gnt_q   <= gnt_nxt;
      data_q  <= data_nxt;
      ch_q    <= ch_nxt;
      valid_q <= valid_nxt;
    end
  end

  assign s0        = sel[0];
  assign s1        = sel[1];
  assign s2        = sel[2];
  assign gnt       = gnt_q;
  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed phases from the plan followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] mux_y;
  logic       s0, s1, s2;
  logic [7:0] gnt;
  logic [7:0] out_data;
  logic [2:0] out_ch;
  logic       out_valid;
  logic       out_ready;

  logic [7:0] mux_data [8];

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         m_last  = 7;
  int         m_sel   = 0;
  logic [7:0] m_gnt   = 8'h00;
  logic [7:0] m_data  = 8'h00;
  int         m_ch    = 0;
  logic       m_valid = 1'b0;
  logic       m_cap   = 1'b0;

  // Observed capture log
  logic       log_en = 1'b0;
  logic       prev_valid = 1'b0;
  int         seen_ch[$];

  mux_rr_arbiter #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mux_y     (mux_y),
    .s0        (s0),
    .s1        (s1),
    .s2        (s2),
    .gnt       (gnt),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Combinational 8:1 byte mux driven by the DUT select lines.
  assign mux_y = mux_data[{s2, s1, s0}];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input int last, input logic [7:0] r);
    for (int k = 1; k <= 8; k++) begin
      if (r[(last + k) % 8]) return (last + k) % 8;
    end
    return -1;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model step on each edge, then compare DUT outputs shortly after.
  always @(posedge clk) begin
    bit do_arb;
    int w;
    do_arb = 1'b0;
    if (rst) begin
      m_last = 7; m_sel = 0; m_gnt = 8'h00; m_data = 8'h00;
      m_ch = 0; m_valid = 1'b0; m_cap = 1'b0;
    end else begin
      m_gnt = 8'h00;
      if (m_cap) begin
        m_data  = mux_data[m_sel];
        m_ch    = m_sel;
        m_valid = 1'b1;
        m_cap   = 1'b0;
      end else if (!m_valid) begin
        do_arb = (req != 8'h00);
      end else if (out_ready) begin
        m_valid = 1'b0;
        do_arb  = (req != 8'h00);
      end
      if (do_arb) begin
        w      = pick(m_last, req);
        m_sel  = w;
        m_gnt  = 8'(1 << w);
        m_last = w;
        m_cap  = 1'b1;
      end
    end
    #1;
    check("sel",       32'({s2, s1, s0}), 32'(m_sel));
    check("gnt",       32'(gnt),          32'(m_gnt));
    check("out_valid", 32'(out_valid),    32'(m_valid));
    check("out_data",  32'(out_data),     32'(m_data));
    check("out_ch",    32'(out_ch),       32'(m_ch));
    check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    if (log_en && out_valid && !prev_valid) seen_ch.push_back(int'(out_ch));
    prev_valid = out_valid;
  end

  initial begin
    rst = 1'b1; req = 8'h00; out_ready = 1'b0;
    for (int k = 0; k < 8; k++) mux_data[k] = 8'(8'h10 + k);
    mux_data[0] = 8'hA5;

    // Reset, then first request to channel 0
    cyc(2);
    rst = 1'b0;
    cyc(1);
    req = 8'h01;
    cyc(1);
    req = 8'h00;
    cyc(3);
    out_ready = 1'b1;
    cyc(2);

    // Single channel 3
    mux_data[0] = 8'h10;
    req = 8'h08;
    cyc(1);
    req = 8'h00;
    cyc(4);

    // Full load continues round-robin after channel 3
    seen_ch.delete();
    log_en = 1'b1;
    req = 8'hFF;
    cyc(20);
    req = 8'h00;
    log_en = 1'b0;
    cyc(3);
    check("full_count", 32'(seen_ch.size() >= 10), 32'd1);
    for (int i = 0; i < 10 && i < seen_ch.size(); i++)
      check("full_seq", 32'(seen_ch[i]), 32'((4 + i) % 8));

    // Wrap and fairness
    req = 8'h81;
    cyc(8);
    req = 8'h40;
    cyc(1);
    req = 8'h00;
    cyc(4);
    req = 8'h20;
    cyc(1);
    req = 8'h00;
    cyc(4);

    // Backpressure
    out_ready = 1'b0;
    req = 8'hFF;
    cyc(8);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    cyc(4);
    out_ready = 1'b1;
    req = 8'h00;
    cyc(4);

    // Reset during CAPTURE
    req = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      if (gnt != 8'h00) break;
      cyc(1);
    end
    check("wait_gnt", 32'(gnt != 8'h00), 32'd1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    req = 8'h00;
    cyc(2);
    req = 8'h80;
    cyc(1);
    req = 8'h00;
    cyc(4);

    // Reset during WAIT
    out_ready = 1'b0;
    req = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      cyc(1);
    end
    check("wait_valid", 32'(out_valid), 32'd1);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    req = 8'h81;
    cyc(1);
    req = 8'h00;
    out_ready = 1'b1;
    cyc(4);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       req = 8'h00;
        1:       req = 8'(1 << $urandom_range(0, 7));
        default: req = 8'($urandom);
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 7) == 0) mux_data[$urandom_range(0, 7)] = 8'($urandom);
      cyc(1);
    end
    rst = 1'b0;
    req = 8'h00;
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
